// File: rtl/log_pkg.sv
// rtl/log_pkg.sv - shared record geometry and drain FSM encoding
package log_pkg;
   localparam int REC_W         = 37;
   localparam int PAD_W         = 40;
   localparam int BYTES_PER_REC = 5;
   localparam int IDX_W         = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;
endpackage

// File: rtl/log_fifo.sv
// rtl/log_fifo.sv - record FIFO with occupancy count and synchronous flush
module log_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 37
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           wr_data,
   output logic [W-1:0]           rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          do_push, do_pop;

   assign full    = (level_q == FULL_LVL);
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign rd_data = mem_q[rd_ptr_q];

   // A pop frees the slot in the same cycle, so a full FIFO still takes a push.
   assign do_pop  = pop && !empty && !clr;
   assign do_push = push && (!full || do_pop) && !clr;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      level_d = level_q + 1'b1;
         else if (!do_push && do_pop) level_d = level_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end
endmodule

// File: rtl/log_drain.sv
// rtl/log_drain.sv - buffers logger records and streams each as five MSB-first bytes
module log_drain
   import log_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int REC_W = log_pkg::REC_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   log_we,
   input  logic [REC_W-1:0]       log_data,
   input  logic                   clr,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   output logic [7:0]             tx_byte,
   output logic                   overflow,
   output logic [15:0]            drop_cnt,
   output logic [$clog2(DEPTH):0] level
);
   logic             fifo_full, fifo_empty;
   logic             push, pop, drop, tx_fire, last_byte;
   logic [REC_W-1:0] head;
   state_e           state_q, state_d;
   logic [PAD_W-1:0] shift_q, shift_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             overflow_q, overflow_d;
   logic [15:0]      drop_cnt_q, drop_cnt_d;

   log_fifo #(
      .DEPTH (DEPTH),
      .W     (REC_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .push    (push),
      .pop     (pop),
      .wr_data (log_data),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (level)
   );

   assign push      = log_we && !clr;
   assign tx_fire   = tx_valid && tx_ready;
   assign last_byte = (idx_q == IDX_W'(BYTES_PER_REC - 1));
   assign drop      = log_we && fifo_full && !pop && !clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (!fifo_empty) state_d = ST_SEND;
            ST_SEND: if (tx_fire && last_byte) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      tx_valid = (state_q == ST_SEND);
      pop      = (state_q == ST_IDLE) && !fifo_empty && !clr;
   end

   // Shifting out all five bytes leaves the register zero, so tx_byte idles at 0.
   always_comb begin
      shift_d    = shift_q;
      idx_d      = idx_q;
      overflow_d = overflow_q | drop;
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
      if (clr) begin
         shift_d    = '0;
         idx_d      = '0;
         overflow_d = 1'b0;
         drop_cnt_d = '0;
      end else if (pop) begin
         shift_d = PAD_W'(head);
         idx_d   = '0;
      end else if (tx_fire) begin
         shift_d = shift_q << 8;
         idx_d   = last_byte ? '0 : idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q    <= '0;
         idx_q      <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         shift_q    <= shift_d;
         idx_q      <= idx_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign tx_byte  = shift_q[PAD_W-1 -: 8];
   assign overflow = overflow_q;
   assign drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_log_drain.sv
// tb/tb_log_drain.sv - directed scoreboard bench for log_drain
module tb_log_drain;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        log_we;
   logic [36:0] log_data;
   logic        clr;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  tx_byte;
   logic        overflow;
   logic [15:0] drop_cnt;
   logic [3:0]  level;

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q[$];

   log_drain #(.DEPTH(8), .REC_W(37)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .log_we   (log_we),
      .log_data (log_data),
      .clr      (clr),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_byte  (tx_byte),
      .overflow (overflow),
      .drop_cnt (drop_cnt),
      .level    (level)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rec_byte(input logic [36:0] rec, input int i);
      logic [39:0] p;
      p = {3'b000, rec};
      return p[39-8*i -: 8];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Handshakes are sampled at the falling edge, results read 1 time unit after the rising edge.
   task automatic tick();
      logic [8:0] exp_b;
      @(negedge clk);
      if (tx_valid && tx_ready && !clr && rst_n) begin
         exp_b = (exp_q.size() != 0) ? {1'b1, exp_q.pop_front()} : 9'h000;
         check("tx_byte", {55'd0, 1'b1, tx_byte}, {55'd0, exp_b});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_rec(input logic [36:0] rec, input bit accept);
      log_we   = 1'b1;
      log_data = rec;
      if (accept) for (int i = 0; i < 5; i++) exp_q.push_back(rec_byte(rec, i));
      tick();
      log_we = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      tx_ready = 1'b1;
      while ((exp_q.size() != 0 || tx_valid) && n < 300) begin
         tick();
         n++;
      end
      check(tag, {63'd0, (exp_q.size() == 0 && !tx_valid)}, 64'd1);
   endtask

   initial begin
      logic [36:0] rec;
      logic [63:0] rnd;
      logic [7:0]  held;

      rst_n = 1'b0; log_we = 1'b0; log_data = '0; clr = 1'b0; tx_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", tx_valid, 0);
      check("rst_byte", tx_byte, 0);
      check("rst_level", level, 0);
      check("rst_ovf", overflow, 0);
      check("rst_drop", drop_cnt, 0);
      rst_n = 1'b1;
      tick();

      // single record, latency and five consecutive bytes
      tx_ready = 1'b1;
      send_rec(37'h1F_0000_0003, 1'b1);
      check("lat_n_valid", tx_valid, 0);
      check("lat_n_level", level, 1);
      tick();
      check("lat_n1_valid", tx_valid, 1);
      check("lat_n1_byte", tx_byte, 8'h1F);
      for (int i = 0; i < 5; i++) begin
         check("seq_valid", tx_valid, 1);
         tick();
      end
      check("seq_idle", tx_valid, 0);
      check("seq_empty", exp_q.size(), 0);

      // back-pressure mid-record
      send_rec(37'h0A_BCDE_F012, 1'b1);
      tick();
      tick();
      tick();
      tx_ready = 1'b0;
      held = tx_byte;
      check("stall_front", held, exp_q[0]);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("stall_byte", tx_byte, held);
         check("stall_valid", tx_valid, 1);
      end
      drain("stall_drain");

      // back-to-back records
      for (int i = 0; i < 4; i++) begin
         rnd = {$urandom(), $urandom()};
         send_rec(rnd[36:0], 1'b1);
      end
      drain("b2b_drain");

      // overflow: first record sits in the shift register, eight more fill the FIFO
      tx_ready = 1'b0;
      for (int k = 1; k <= 11; k++) begin
         rnd = {$urandom(), $urandom()};
         send_rec(rnd[36:0], k <= 9);
         if (k == 9) begin
            check("ovf9_level", level, 8);
            check("ovf9_flag", overflow, 0);
            check("ovf9_drop", drop_cnt, 0);
         end
         if (k == 10) begin
            check("ovf10_flag", overflow, 1);
            check("ovf10_drop", drop_cnt, 1);
         end
         if (k == 11) begin
            check("ovf11_drop", drop_cnt, 2);
            check("ovf11_level", level, 8);
         end
      end

      // full FIFO: push and IDLE pop on the same edge
      tx_ready = 1'b1;
      repeat (5) tick();
      check("full_idle_valid", tx_valid, 0);
      check("full_idle_level", level, 8);
      tx_ready = 1'b0;
      send_rec(37'h15_5555_AAAA, 1'b1);
      check("pushpop_level", level, 8);
      check("pushpop_drop", drop_cnt, 2);
      check("pushpop_valid", tx_valid, 1);
      drain("full_drain");

      // clr during byte 2 with three records queued
      tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rec = 37'h01_0000_0000 + 37'(i);
         send_rec(rec, 1'b1);
      end
      check("preclr_level", level, 3);
      check("preclr_ovf", overflow, 1);
      tx_ready = 1'b1;
      tick();
      tick();
      clr = 1'b1;
      log_we = 1'b1;
      log_data = 37'h1E_EEEE_EEEE;
      tick();
      clr = 1'b0;
      log_we = 1'b0;
      exp_q.delete();
      check("clr_valid", tx_valid, 0);
      check("clr_level", level, 0);
      check("clr_drop", drop_cnt, 0);
      check("clr_ovf", overflow, 0);
      check("clr_byte", tx_byte, 0);
      tick();
      check("clr_stay_idle", tx_valid, 0);

      // asynchronous reset mid-SEND
      tx_ready = 1'b1;
      send_rec(37'h12_3456_789A, 1'b1);
      send_rec(37'h0B_0B0B_0B0B, 1'b1);
      tick();
      check("prerst_level", level, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", tx_valid, 0);
      check("arst_byte", tx_byte, 0);
      check("arst_level", level, 0);
      exp_q.delete();
      tick();
      #2 rst_n = 1'b1;
      rec = 37'h07_C0DE_1234;
      send_rec(rec, 1'b1);
      tick();
      check("post_rst_valid", tx_valid, 1);
      check("post_rst_byte0", tx_byte, rec_byte(rec, 0));
      drain("post_rst_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
